// File: rtl/paddle.sv
// Paddle position controller: two raw buttons are synchronised, debounced and
// turned into one-row steps with hold-to-repeat, clamped to the 16-row matrix.
module paddle #(
    parameter int DEBOUNCE = 4,
    parameter int REPEAT   = 8,
    parameter int HEIGHT   = 4,
    parameter int INIT_Y   = 6
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       freeze,
    output logic [3:0] y,
    output logic       moved
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam int TW = (REPEAT > 1) ? $clog2(REPEAT) : 1;
    localparam logic [4:0]    YMAX      = 5'(16 - HEIGHT);
    localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE - 1);
    localparam logic [TW-1:0] TIMER_END = TW'(REPEAT - 1);

    typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DOWN} dir_t;

    logic [1:0]    raw;
    logic [1:0]    sync1;
    logic [1:0]    sync2;
    logic [1:0]    deb;
    logic [CW-1:0] cnt [2];
    logic [TW-1:0] timer;
    dir_t          dir;
    dir_t          prev_dir;
    logic          step;

    // bit 0 is the up button, bit 1 the down button
    assign raw = {btn_down, btn_up};

    // A level is accepted only after it differs from the debounced value for
    // DEBOUNCE consecutive cycles; any agreement restarts the count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
            deb   <= '0;
            for (int i = 0; i < 2; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
            for (int i = 0; i < 2; i++) begin
                if (sync2[i] == deb[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == DEB_LAST) begin
                    deb[i] <= sync2[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CW'(1);
                end
            end
        end
    end

    always_comb begin
        dir = DIR_NONE;
        if (deb[0] && !deb[1]) begin
            dir = DIR_UP;
        end else if (deb[1] && !deb[0]) begin
            dir = DIR_DOWN;
        end
    end

    // A direction that differs from last cycle's is a fresh press and steps at once.
    assign step = !freeze && (dir != DIR_NONE) &&
                  ((dir != prev_dir) || (timer == TIMER_END));

    // prev_dir is forced to NONE while frozen so that unfreezing with a button
    // still held looks like a new press.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y        <= 4'(INIT_Y);
            moved    <= 1'b0;
            timer    <= '0;
            prev_dir <= DIR_NONE;
        end else begin
            moved <= 1'b0;
            if (freeze || dir == DIR_NONE) begin
                timer    <= '0;
                prev_dir <= DIR_NONE;
            end else begin
                prev_dir <= dir;
                if (dir != prev_dir || timer == TIMER_END) begin
                    timer <= '0;
                end else begin
                    timer <= timer + TW'(1);
                end
                if (step) begin
                    if (dir == DIR_UP && y != 4'd0) begin
                        y     <= y - 4'd1;
                        moved <= 1'b1;
                    end else if (dir == DIR_DOWN && {1'b0, y} < YMAX) begin
                        y     <= y + 4'd1;
                        moved <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_paddle.sv
// Randomised self-checking bench for paddle, compared cycle by cycle against a
// behavioural model built from the button/step rules.
module tb_paddle;

    localparam int DEBOUNCE = 4;
    localparam int REPEAT   = 8;
    localparam int HEIGHT   = 4;
    localparam int INIT_Y   = 6;
    localparam int YMAX     = 16 - HEIGHT;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       btn_up = 1'b0;
    logic       btn_down = 1'b0;
    logic       freeze = 1'b0;
    logic [3:0] y;
    logic       moved;

    int testsRun = 0;
    int testsFailed = 0;
    int movedCount = 0;

    // reference model state
    int          modelY;
    int          modelMoved;
    bit          ms1 [2];
    bit          ms2 [2];
    bit          mdeb [2];
    logic [31:0] win [2];
    int          since [2];
    int          runLen;
    int          runDir;

    paddle #(
        .DEBOUNCE(DEBOUNCE),
        .REPEAT(REPEAT),
        .HEIGHT(HEIGHT),
        .INIT_Y(INIT_Y)
    ) dut (
        .clk(clk),
        .reset(reset),
        .btn_up(btn_up),
        .btn_down(btn_down),
        .freeze(freeze),
        .y(y),
        .moved(moved)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int obs, input int exp);
        testsRun++;
        if (obs != exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        modelY = INIT_Y;
        modelMoved = 0;
        runLen = 0;
        runDir = 0;
        for (int i = 0; i < 2; i++) begin
            ms1[i] = 1'b0;
            ms2[i] = 1'b0;
            mdeb[i] = 1'b0;
            win[i] = '0;
            since[i] = 0;
        end
    endtask

    // One clock edge of the model: a button level is accepted once the last
    // DEBOUNCE synchronised samples since the previous change all disagree.
    task automatic modelEdge();
        int dir;
        bit rawv [2];
        logic [31:0] mask;
        if (!reset) begin
            modelReset();
            return;
        end
        dir = (mdeb[0] && !mdeb[1]) ? 1 : (mdeb[1] && !mdeb[0]) ? 2 : 0;
        modelMoved = 0;
        if (freeze || dir == 0) begin
            runLen = 0;
            runDir = 0;
        end else begin
            if (dir != runDir) begin
                runLen = 1;
                runDir = dir;
            end else begin
                runLen++;
            end
            if ((runLen - 1) % REPEAT == 0) begin
                if (dir == 1 && modelY > 0) begin
                    modelY--;
                    modelMoved = 1;
                end else if (dir == 2 && modelY < YMAX) begin
                    modelY++;
                    modelMoved = 1;
                end
            end
        end
        mask = (32'd1 << DEBOUNCE) - 32'd1;
        rawv[0] = btn_up;
        rawv[1] = btn_down;
        for (int i = 0; i < 2; i++) begin
            win[i] = {win[i][30:0], ms2[i]};
            since[i]++;
            if (since[i] >= DEBOUNCE &&
                ((mdeb[i] && (win[i] & mask) == 32'd0) ||
                 (!mdeb[i] && (win[i] & mask) == mask))) begin
                mdeb[i] = !mdeb[i];
                since[i] = 0;
            end
            ms2[i] = ms1[i];
            ms1[i] = rawv[i];
        end
    endtask

    task automatic applyStimulus(input bit up, input bit dn, input bit fr, input int n);
        btn_up = up;
        btn_down = dn;
        freeze = fr;
        repeat (n) begin
            @(posedge clk);
            modelEdge();
            if (modelMoved != 0) movedCount++;
            #1;
            checkOutput("y", int'(y), modelY);
            checkOutput("moved", int'(moved), modelMoved);
        end
    endtask

    task automatic doReset();
        reset = 1'b0;
        modelReset();
        applyStimulus(0, 0, 0, 2);
        reset = 1'b1;
    endtask

    initial begin
        bit up;
        bit dn;
        bit fr;
        modelReset();
        @(posedge clk);
        #1;
        checkOutput("reset_y", int'(y), INIT_Y);
        checkOutput("reset_moved", int'(moved), 0);
        doReset();
        applyStimulus(0, 0, 0, 100);
        checkOutput("idle_y", int'(y), 6);

        // press latency and repeat spacing
        applyStimulus(0, 1, 0, 6);
        checkOutput("press_before", int'(y), 6);
        applyStimulus(0, 1, 0, 1);
        checkOutput("press_y", int'(y), 7);
        checkOutput("press_moved", int'(moved), 1);
        applyStimulus(0, 1, 0, 8);
        checkOutput("repeat1_y", int'(y), 8);
        applyStimulus(0, 1, 0, 8);
        checkOutput("repeat2_y", int'(y), 9);
        applyStimulus(0, 0, 0, 40);
        checkOutput("release_y", int'(y), 9);

        // short glitches are discarded
        doReset();
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1, 0, 0, 1 + k % 3);
            applyStimulus(0, 0, 0, 2 + k % 3);
        end
        checkOutput("glitch_y", int'(y), 6);

        // clamp at bottom
        doReset();
        movedCount = 0;
        applyStimulus(0, 1, 0, 200);
        checkOutput("clamp_bot_y", int'(y), 12);
        checkOutput("clamp_bot_moves", movedCount, 6);

        // clamp at top
        doReset();
        applyStimulus(1, 0, 0, 100);
        checkOutput("clamp_top_y", int'(y), 0);

        // both buttons held, then down released
        doReset();
        applyStimulus(1, 1, 0, 30);
        checkOutput("both_y", int'(y), 6);
        applyStimulus(1, 0, 0, 10);
        checkOutput("both_release_y", int'(y), 5);

        // freeze, unfreeze, async reset mid-hold
        doReset();
        applyStimulus(1, 0, 1, 50);
        checkOutput("freeze_y", int'(y), 6);
        applyStimulus(1, 0, 0, 1);
        checkOutput("unfreeze_y", int'(y), 5);
        checkOutput("unfreeze_moved", int'(moved), 1);
        applyStimulus(1, 0, 0, 3);
        reset = 1'b0;
        modelReset();
        #1;
        checkOutput("async_reset_y", int'(y), INIT_Y);
        checkOutput("async_reset_moved", int'(moved), 0);
        applyStimulus(1, 0, 0, 3);
        reset = 1'b1;
        applyStimulus(1, 0, 0, 6);
        checkOutput("rehold_wait_y", int'(y), 6);
        applyStimulus(1, 0, 0, 4);
        checkOutput("rehold_y", int'(y), 5);

        // randomised holds, overlaps, freezes and resets
        doReset();
        for (int k = 0; k < 200; k++) begin
            if ($urandom_range(0, 39) == 0) begin
                doReset();
            end
            up = ($urandom_range(0, 2) == 0);
            dn = ($urandom_range(0, 2) == 0);
            fr = ($urandom_range(0, 7) == 0);
            applyStimulus(up, dn, fr, $urandom_range(1, 24));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
